// File: rtl/fp_div_pkg.sv
// Shared types and constants for the iterative single-precision divider.
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int          BIAS    = 127;
  localparam int          QBITS   = 26;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  INF_EXP = 8'hFF;

  // Bit positions inside flags = {invalid, div_by_zero, overflow, underflow}
  localparam int FLAG_INVALID = 3;
  localparam int FLAG_DBZ     = 2;
  localparam int FLAG_OVF     = 1;
  localparam int FLAG_UNF     = 0;

endpackage

// File: rtl/fp_div_special.sv
// Operand classifier: flags NaN/inf/zero (denormals count as zero) and
// supplies the final result for every operand pair that skips the divide loop.
import fp_div_pkg::*;

module fp_div_special (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] special_result,
  output logic [3:0]  special_flags
);

  logic sign;
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  assign sign   = a[31] ^ b[31];
  assign a_zero = (a[30:23] == 8'd0);
  assign a_inf  = (a[30:23] == INF_EXP) && (a[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == INF_EXP) && (a[22:0] != 23'd0);
  assign b_zero = (b[30:23] == 8'd0);
  assign b_inf  = (b[30:23] == INF_EXP) && (b[22:0] == 23'd0);
  assign b_nan  = (b[30:23] == INF_EXP) && (b[22:0] != 23'd0);

  // Priority decode of the special cases; invalid beats divide-by-zero beats inf/zero.
  always_comb begin
    is_special     = 1'b0;
    special_result = 32'd0;
    special_flags  = 4'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      is_special                  = 1'b1;
      special_result              = QNAN;
      special_flags[FLAG_INVALID] = 1'b1;
    end else if (b_zero && !a_inf) begin
      is_special              = 1'b1;
      special_result          = {sign, INF_EXP, 23'd0};
      special_flags[FLAG_DBZ] = 1'b1;
    end else if (a_inf) begin
      is_special     = 1'b1;
      special_result = {sign, INF_EXP, 23'd0};
    end else if (a_zero || b_inf) begin
      is_special     = 1'b1;
      special_result = {sign, 31'd0};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider, one quotient bit per clock.
// Define FP_DIV_RNE_EN for round-to-nearest-even; default build truncates.
import fp_div_pkg::*;

module fp_div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  state_t             state;
  logic [24:0]        rem;
  logic [24:0]        dvs;
  logic [QBITS-1:0]   quo;
  logic signed [9:0]  exp_q;
  logic [4:0]         cnt;
  logic               sign_q;
  logic               special_q;
  logic [31:0]        spec_result_q;
  logic [3:0]         spec_flags_q;

  logic               is_special;
  logic [31:0]        special_result;
  logic [3:0]         special_flags;

  logic               accept;
  logic               q_bit;
  logic [24:0]        rem_next;

  logic signed [9:0]  exp_n;
  logic [22:0]        mant_n;
  logic               guard_n;
  logic               sticky_n;
  logic signed [9:0]  exp_r;
  logic [22:0]        mant_r;
  logic [31:0]        norm_result;
  logic [3:0]         norm_flags;

  assign accept = in_valid & in_ready;

  fp_div_special u_special (
    .a              (a),
    .b              (b),
    .is_special     (is_special),
    .special_result (special_result),
    .special_flags  (special_flags)
  );

`ifdef FP_DIV_RNE_EN
  function automatic logic [23:0] round_rne(input logic [22:0] m, input logic g, input logic s);
    return {1'b0, m} + {23'd0, g & (s | m[0])};
  endfunction
`endif

  // Exponent range check: saturate to signed inf or flush to signed zero.
  function automatic logic [35:0] pack_result(input logic s, input logic signed [9:0] e,
                                              input logic [22:0] m);
    logic [31:0] r;
    logic [3:0]  f;
    f = 4'd0;
    if (e >= 10'sd255) begin
      r           = {s, INF_EXP, 23'd0};
      f[FLAG_OVF] = 1'b1;
    end else if (e <= 10'sd0) begin
      r           = {s, 31'd0};
      f[FLAG_UNF] = 1'b1;
    end else begin
      r = {s, e[7:0], m};
    end
    return {r, f};
  endfunction

  // Restoring step: subtract the divisor when it fits, then shift the remainder.
  always_comb begin
    q_bit    = 1'b0;
    rem_next = rem << 1;
    if (rem >= dvs) begin
      q_bit    = 1'b1;
      rem_next = (rem - dvs) << 1;
    end
  end

  // Normalize the quotient, round, and pack the final word.
  always_comb begin
    exp_n    = exp_q;
    mant_n   = quo[QBITS-2:2];
    guard_n  = quo[1];
    sticky_n = quo[0] | (|rem);
    if (!quo[QBITS-1]) begin
      mant_n   = quo[QBITS-3:1];
      guard_n  = quo[0];
      sticky_n = |rem;
      exp_n    = exp_q - 10'sd1;
    end
`ifdef FP_DIV_RNE_EN
    {exp_r[0], mant_r} = round_rne(mant_n, guard_n, sticky_n);
    exp_r = exp_n + $signed({9'd0, exp_r[0]});
`else
    mant_r = mant_n;
    exp_r  = exp_n;
`endif
    {norm_result, norm_flags} = pack_result(sign_q, exp_r, mant_r);
  end

`ifndef FP_DIV_RNE_EN
  logic unused_round;
  assign unused_round = guard_n ^ sticky_n;
`endif

  // Control FSM with registered handshake, done pulse and held result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      done          <= 1'b0;
      result        <= 32'd0;
      flags         <= 4'd0;
      rem           <= 25'd0;
      dvs           <= 25'd0;
      quo           <= '0;
      exp_q         <= 10'sd0;
      cnt           <= 5'd0;
      sign_q        <= 1'b0;
      special_q     <= 1'b0;
      spec_result_q <= 32'd0;
      spec_flags_q  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            in_ready      <= 1'b0;
            sign_q        <= a[31] ^ b[31];
            special_q     <= is_special;
            spec_result_q <= special_result;
            spec_flags_q  <= special_flags;
            rem           <= {2'b01, a[22:0]};
            dvs           <= {2'b01, b[22:0]};
            quo           <= '0;
            cnt           <= 5'd0;
            exp_q         <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'(BIAS);
            // Special operands skip the loop and publish on the next edge.
            state         <= is_special ? NORM : DIVIDE;
          end else begin
            state <= IDLE;
          end
        end
        DIVIDE: begin
          rem <= rem_next;
          quo <= {quo[QBITS-2:0], q_bit};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(QBITS - 1)) state <= NORM;
        end
        NORM: begin
          result   <= special_q ? spec_result_q : norm_result;
          flags    <= special_q ? spec_flags_q : norm_flags;
          done     <= 1'b1;
          in_ready <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: vector table plus handshake/reset sequences.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int failures = 0;

  fp_div_seq dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .done     (done),
    .result   (result),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    string       name;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

`ifdef FP_DIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Wait (bounded) for in_ready, present operands, return #1 after the accept edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_wait", {31'd0, in_ready}, 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  initial begin
    int lat;
    int dn;
    int hold_bad;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27, "6_div_2"};
    vecs[1]  = '{32'h3F800000, 32'h40400000, THIRD,        4'b0000, 27, "1_div_3"};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100,  1, "1_div_0"};
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000,  1, "0_div_0"};
    vecs[4]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 27, "overflow"};
    vecs[5]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 27, "underflow"};
    vecs[6]  = '{32'hC0000000, 32'h3F800000, 32'hC0000000, 4'b0000, 27, "neg2_div_1"};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000,  1, "nan_div_1"};
    vecs[8]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000,  1, "inf_div_inf"};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000,  1, "ninf_div_2"};
    vecs[10] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000,  1, "nzero_div_2"};
    vecs[11] = '{32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000,  1, "2_div_ninf"};
    vecs[12] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000,  1, "denorm_div_1"};
    vecs[13] = '{32'h3F800000, 32'h00400000, 32'h7F800000, 4'b0100,  1, "1_div_denorm"};
    vecs[14] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 4'b0100,  1, "n1_div_nzero"};
    vecs[15] = '{32'h40400000, 32'h40000000, 32'h3FC00000, 4'b0000, 27, "3_div_2"};
    vecs[16] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000,  1, "inf_div_0"};

    // Reset state
    #12;
    check("rst_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_done",   {31'd0, done},     32'd0);
    check("rst_result", result,            32'd0);
    check("rst_flags",  {28'd0, flags},    32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy"}, {31'd0, in_ready}, 32'd0);
      wait_done(lat);
      check({vecs[i].name, "_lat"},   lat,             vecs[i].lat);
      check({vecs[i].name, "_res"},   result,          vecs[i].res);
      check({vecs[i].name, "_flags"}, {28'd0, flags},  {28'd0, vecs[i].flg});
      @(posedge clk);
      #1;
      check({vecs[i].name, "_pulse"}, {31'd0, done}, 32'd0);
      check({vecs[i].name, "_hold"},  result,        vecs[i].res);
    end

    // in_valid while busy must be ignored
    start_op(32'h3F800000, 32'h3F800000);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 3) begin
        a = 32'd0;
        b = 32'd0;
        in_valid = 1'b1;
      end
      if (lat == 8) in_valid = 1'b0;
    end while (!done && lat < 40);
    check("busy_lat",   lat,            27);
    check("busy_res",   result,         32'h3F800000);
    check("busy_flags", {28'd0, flags}, 32'd0);

    // Back-to-back: new operands presented in the done cycle
    start_op(32'h40C00000, 32'h40000000);
    wait_done(lat);
    check("b2b_first", result, 32'h40400000);
    a = 32'hC0000000;
    b = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("b2b_accept", {31'd0, in_ready}, 32'd0);
    lat = 0;
    hold_bad = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && result !== 32'h40400000) hold_bad++;
    end while (!done && lat < 40);
    check("b2b_hold", hold_bad, 0);
    check("b2b_lat",  lat,      27);
    check("b2b_res",  result,   32'hC0000000);

    // Reset 10 edges into a divide
    @(posedge clk);
    start_op(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_result", result,            32'd0);
    check("mid_rst_flags",  {28'd0, flags},    32'd0);
    check("mid_rst_done",   {31'd0, done},     32'd0);
    check("mid_rst_ready",  {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check("mid_rst_nodone", dn,                0);
    check("mid_rst_ready2", {31'd0, in_ready}, 32'd1);
    start_op(32'h40400000, 32'h40000000);
    wait_done(lat);
    check("post_rst_lat", lat,    27);
    check("post_rst_res", result, 32'h3FC00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Iterative IEEE-754 single-precision divider for the floating-point ALU. It is the inverse-direction companion to the pipelined Booth multiplier path.
- Computes a/b with a restoring mantissa divider that produces one quotient bit per clock.
- Valid/ready input handshake and a single-cycle done pulse; the result is held until the next completion.
- Sits beside the mul/add units and shares the same exponent and sign handling conventions.

Parameters:
- QBITS, 26, quotient bits generated: 24 mantissa bits, 1 guard bit, 1 normalization bit.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  divider can accept operands
- a  input  32  dividend, IEEE-754 single
- b  input  32  divisor, IEEE-754 single
- done  output  1  one-cycle pulse when result is valid
- result  output  32  quotient, held until next done
- flags  output  4  {invalid, div_by_zero, overflow, underflow}, held with result

Behaviour:
- Reset is asynchronous and active-low, on clock clk. While reset=0: state=IDLE, in_ready=1, done=0, result=0, flags=0, all internal registers 0. Reset mid-operation aborts the divide; no done is produced.
- in_ready=1 in IDLE and DONE, 0 otherwise. An accept occurs on a clk edge with in_valid&in_ready. in_valid while busy is ignored and does not queue.
- Input denormals are treated as zero. Output denormals are flushed to signed zero with underflow=1.
- Sign: a[31]^b[31] for all results, including zero and inf.
- Special cases are decoded at accept, go straight to DONE, and done rises 1 edge after accept. Priority order:
  - NaN operand, 0/0, or inf/inf: result 7FC00000, invalid=1.
  - x/0 (x nonzero, finite): signed inf, div_by_zero=1.
  - inf/finite: signed inf.
  - 0/nonzero or finite/inf: signed zero, no flag.
- Normal path at accept:
  - R := {1'b0,1,ma} (25 b).
  - D := {1'b0,1,mb}.
  - exp := ea - eb + BIAS, held as 10-bit signed.
  - cnt := 0.
  - State goes to DIVIDE.
- DIVIDE, each edge:
  - If R>=D: q bit=1, R:=(R-D)<<1; else q bit=0, R:=R<<1.
  - q shifts in MSB-first; cnt++.
  - After QBITS (26) iterations, state goes to NORM.
- NORM (1 edge):
  - If q[25]=1: mant=q[24:2], guard=q[1], sticky=q[0]|(R!=0).
  - Else: mant=q[23:1], guard=q[0], sticky=(R!=0), exp-=1.
  - Default rounding is truncation (round toward zero).
  - If exp>=255: result=signed inf, overflow=1.
  - If exp<=0: result=signed zero, underflow=1.
  - Result and flags are registered, and state goes to DONE.
- Normal latency: done rises 27 edges after accept; it is high exactly one cycle.
- DONE: done=1 for one cycle. A new accept in DONE is allowed (back-to-back); otherwise state returns to IDLE.
- Result and flags change only on the edge that raises done.

Optional Feature:
- FP_DIV_RNE_EN defined: round-to-nearest-even in NORM. Increment mant when guard&(sticky|mant[0]). A mantissa carry-out increments exp, and the overflow check follows the increment. Latency is unchanged.
- FP_DIV_RNE_EN undefined: truncation only, and no rounding adder is built.

Decomposition:
- Package fp_div_pkg:
  - State enum {IDLE, DIVIDE, NORM, DONE}.
  - BIAS, QBITS, QNAN=32'h7FC00000, INF_EXP=8'hFF.
  - Flag bit indices.
- Sub-module fp_div_special: combinational classifier of a and b (zero/inf/NaN/denormal). Outputs is_special, special_result and special_flags, used at accept.

Test Plan:
- 40C00000 / 40000000 (6/2): result 40400000, flags 0, done exactly 27 edges after accept, in_ready low during the divide.
- 3F800000 / 40400000 (1/3): 3EAAAAAA without the macro; 3EAAAAAB with FP_DIV_RNE_EN.
- 3F800000 / 00000000: result 7F800000, flags=0100, done 1 edge after accept. Then 00000000 / 00000000: 7FC00000, flags=1000.
- 7F000000 / 00800000: result 7F800000, overflow=1. 00800000 / 7F000000: result 00000000, underflow=1. C0000000 / 3F800000: C0000000.
- Back-to-back: second operand pair presented in the done cycle is accepted. Second done occurs 27 edges later, and the first result holds until then.
- Reset pulled low 10 edges into a divide: outputs zero immediately, no done. After release, in_ready=1 and the next divide completes correctly.
